// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter and access sequencer that lets requesters A and B share
// one single-port RAM. All outputs are registered.
module ram_rr_arbiter #(
   parameter int ADDRWIDTH = 4,
   parameter int DATAWIDTH = 8,
   parameter int SIZE      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 a_req,
   input  logic                 a_we,
   input  logic [ADDRWIDTH-1:0] a_addr,
   input  logic [DATAWIDTH-1:0] a_wdata,
   output logic                 a_ack,
   output logic                 a_err,
   output logic                 a_rvalid,
   output logic [DATAWIDTH-1:0] a_rdata,
   input  logic                 b_req,
   input  logic                 b_we,
   input  logic [ADDRWIDTH-1:0] b_addr,
   input  logic [DATAWIDTH-1:0] b_wdata,
   output logic                 b_ack,
   output logic                 b_err,
   output logic                 b_rvalid,
   output logic [DATAWIDTH-1:0] b_rdata,
   output logic                 ram_cs,
   output logic                 ram_we,
   output logic [ADDRWIDTH-1:0] ram_addr,
   output logic [DATAWIDTH-1:0] ram_data,
   input  logic [DATAWIDTH-1:0] ram_dout,
   output logic [1:0]           dbg_state
);

   // Handshake: a requester holds req and its command fields stable until it
   // sees ack, and only in the cycle after ack may drop req or present a new
   // command. Because ack is registered, the req seen on the edge right after
   // an ack still belongs to the command just accepted, so it is masked there.
   typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, RWAIT = 2'd2} state_t;

   localparam logic [ADDRWIDTH:0] LIMIT = (ADDRWIDTH+1)'(SIZE);

   state_t                 state, state_nxt;
   logic                   last_b, last_b_nxt;
   logic                   a_act, b_act, sel_b, sel_we;
   logic [ADDRWIDTH-1:0]   sel_addr;
   logic [DATAWIDTH-1:0]   sel_wdata;
   logic                   cs_nxt, we_nxt;
   logic [ADDRWIDTH-1:0]   addr_nxt;
   logic [DATAWIDTH-1:0]   data_nxt;
   logic                   a_ack_nxt, a_err_nxt, a_rvalid_nxt;
   logic                   b_ack_nxt, b_err_nxt, b_rvalid_nxt;
   logic [DATAWIDTH-1:0]   a_rdata_nxt, b_rdata_nxt;

   assign a_act     = a_req & ~a_ack;
   assign b_act     = b_req & ~b_ack;
   assign dbg_state = state;

   always_comb begin
      sel_b        = b_act & (~a_act | ~last_b);
      sel_we       = sel_b ? b_we    : a_we;
      sel_addr     = sel_b ? b_addr  : a_addr;
      sel_wdata    = sel_b ? b_wdata : a_wdata;
      state_nxt    = state;
      last_b_nxt   = last_b;
      cs_nxt       = 1'b0;
      we_nxt       = 1'b0;
      addr_nxt     = ram_addr;
      data_nxt     = ram_data;
      a_ack_nxt    = 1'b0;
      a_err_nxt    = 1'b0;
      a_rvalid_nxt = 1'b0;
      a_rdata_nxt  = a_rdata;
      b_ack_nxt    = 1'b0;
      b_err_nxt    = 1'b0;
      b_rvalid_nxt = 1'b0;
      b_rdata_nxt  = b_rdata;
      case (state)
         IDLE: begin
            if (a_act | b_act) begin
               last_b_nxt = sel_b;
               a_ack_nxt  = ~sel_b;
               b_ack_nxt  = sel_b;
               if ({1'b0, sel_addr} < LIMIT) begin
                  cs_nxt    = 1'b1;
                  we_nxt    = sel_we;
                  addr_nxt  = sel_addr;
                  data_nxt  = sel_wdata;
                  state_nxt = CMD;
               end else begin
                  a_err_nxt = ~sel_b;
                  b_err_nxt = sel_b;
               end
            end
         end
         CMD: state_nxt = ram_we ? IDLE : RWAIT;
         RWAIT: begin
            // last_b still names the owner of the read in flight
            if (last_b) begin
               b_rdata_nxt  = ram_dout;
               b_rvalid_nxt = 1'b1;
            end else begin
               a_rdata_nxt  = ram_dout;
               a_rvalid_nxt = 1'b1;
            end
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         last_b   <= 1'b1;
         ram_cs   <= 1'b0;
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_data <= '0;
         a_ack    <= 1'b0;
         a_err    <= 1'b0;
         a_rvalid <= 1'b0;
         a_rdata  <= '0;
         b_ack    <= 1'b0;
         b_err    <= 1'b0;
         b_rvalid <= 1'b0;
         b_rdata  <= '0;
      end else begin
         state    <= state_nxt;
         last_b   <= last_b_nxt;
         ram_cs   <= cs_nxt;
         ram_we   <= we_nxt;
         ram_addr <= addr_nxt;
         ram_data <= data_nxt;
         a_ack    <= a_ack_nxt;
         a_err    <= a_err_nxt;
         a_rvalid <= a_rvalid_nxt;
         a_rdata  <= a_rdata_nxt;
         b_ack    <= b_ack_nxt;
         b_err    <= b_err_nxt;
         b_rvalid <= b_rvalid_nxt;
         b_rdata  <= b_rdata_nxt;
      end
   end

endmodule
